// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: arbiter state
// encoding, default word/line geometry and the line-width derivation.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_SIZE_DEF  = 16;
  localparam int unsigned LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  function automatic int unsigned line_width(input int unsigned words,
                                             input int unsigned word_size);
    return words * word_size;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter used for the arbiter statistics.
// Ports: clk, reset (sync, active-high), inc (count one), clear (sync zero),
//        count (holds at all-ones once reached).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one line-wide memory port between the instruction-fetch
// side (I, read-only) and the data side (D, read/write). D has fixed priority;
// a starvation guard forces an I grant after STARVE_LIMIT consecutive D grants
// taken while I was waiting.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_read/i_address           I line read request (held until i_ready)
//   i_data/i_ready             I read line and one-cycle completion pulse
//   d_read/d_write/d_address/d_wdata   D line request (held until d_ready)
//   d_data/d_ready             D read line and one-cycle completion pulse
//   m_read/m_write/m_address/m_wdata   registered memory request
//   m_rdata/m_ready            memory read line and completion pulse
//   num_i_grants/num_d_grants/num_i_wait   saturating statistics
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int unsigned WORD_SIZE    = WORD_SIZE_DEF,
  parameter  int unsigned LINE_WORDS   = LINE_WORDS_DEF,
  parameter  int unsigned STARVE_LIMIT = 3,
  parameter  int unsigned CNT_W        = 16,
  localparam int unsigned LINE_W       = line_width(LINE_WORDS, WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_read,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [LINE_W-1:0]    i_data,
  output logic                 i_ready,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [LINE_W-1:0]    d_wdata,
  output logic [LINE_W-1:0]    d_data,
  output logic                 d_ready,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [LINE_W-1:0]    m_wdata,
  input  logic [LINE_W-1:0]    m_rdata,
  input  logic                 m_ready,
  output logic [CNT_W-1:0]     num_i_grants,
  output logic [CNT_W-1:0]     num_d_grants,
  output logic [CNT_W-1:0]     num_i_wait
);

  localparam int unsigned ST_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [ST_W-1:0]      STARVE_MAX = ST_W'(STARVE_LIMIT);
  localparam logic [WORD_SIZE-1:0] ADDR_MASK  = ~WORD_SIZE'(3);

  arb_state_t      state;
  logic [ST_W-1:0] starve;
  logic            d_req;
  logic            i_forced;
  logic            mem_done;

  assign d_req    = d_read | d_write;
  assign i_forced = i_read && (starve == STARVE_MAX);

  // A completion arriving while reset is asserted belongs to an abandoned
  // transaction and must not reach either requester or the counters.
  assign mem_done = m_ready && !reset;
  assign i_ready  = mem_done && (state == GRANT_I);
  assign d_ready  = mem_done && (state == GRANT_D);
  assign i_data   = i_ready ? m_rdata : '0;
  assign d_data   = d_ready ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      starve    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !i_forced) begin
            state     <= GRANT_D;
            m_address <= d_address & ADDR_MASK;
            m_wdata   <= d_wdata;
            m_write   <= d_write;
            m_read    <= !d_write;
            if (!i_read) begin
              starve <= '0;
            end else if (starve != STARVE_MAX) begin
              starve <= starve + ST_W'(1);
            end
          end else if (i_read) begin
            state     <= GRANT_I;
            m_address <= i_address & ADDR_MASK;
            m_read    <= 1'b1;
            m_write   <= 1'b0;
            starve    <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (m_ready) begin
            state   <= IDLE;
            m_read  <= 1'b0;
            m_write <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          m_read  <= 1'b0;
          m_write <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_i_grants (
    .clk   (clk),
    .reset (reset),
    .inc   (i_ready),
    .clear (1'b0),
    .count (num_i_grants)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_grants (
    .clk   (clk),
    .reset (reset),
    .inc   (d_ready),
    .clear (1'b0),
    .count (num_d_grants)
  );

  sat_counter #(.CNT_W(CNT_W)) u_i_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (i_read && (state != GRANT_I)),
    .clear (1'b0),
    .count (num_i_wait)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses,
// a negedge monitor pops and compares on every ready pulse.
module tb_mem_port_arbiter;

  localparam int unsigned CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic [63:0] i_data;
  logic        i_ready;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_address = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_data;
  logic        d_ready;
  logic        m_read;
  logic        m_write;
  logic [15:0] m_address;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ready;
  logic [CW-1:0] num_i_grants;
  logic [CW-1:0] num_d_grants;
  logic [CW-1:0] num_i_wait;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_SIZE(16), .LINE_WORDS(4), .STARVE_LIMIT(3), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_data(d_data), .d_ready(d_ready),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .num_i_grants(num_i_grants), .num_d_grants(num_d_grants), .num_i_wait(num_i_wait)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    logic        wr;
  } exp_t;

  exp_t i_exp[$];
  exp_t d_exp[$];
  byte  order_q[$];
  logic [63:0] ref_mem[logic [15:0]];
  logic [63:0] phys_mem[logic [15:0]];

  int unsigned mem_lat_min = 0;
  int unsigned mem_lat_max = 3;
  logic        inject = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [63:0] init_line(input logic [15:0] a);
    logic [15:0] k;
    k = a & 16'hFFFC;
    return {k, ~k, k ^ 16'h5A5A, k + 16'd1};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [15:0] a);
    logic [15:0] k;
    k = a & 16'hFFFC;
    return ref_mem.exists(k) ? ref_mem[k] : init_line(k);
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Memory model: completes each strobed request after a random latency.
  bit          mem_busy = 1'b0;
  int unsigned mem_cnt  = 0;
  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      m_ready = 1'b0;
      m_rdata = '0;
      if (inject) begin
        m_ready = 1'b1;
        inject  = 1'b0;
      end else if (m_read || m_write) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = $urandom_range(mem_lat_max, mem_lat_min);
        end
        if (mem_cnt == 0) begin
          m_ready = 1'b1;
          if (m_write) phys_mem[m_address] = m_wdata;
          else m_rdata = phys_mem.exists(m_address) ? phys_mem[m_address] : init_line(m_address);
        end else begin
          mem_cnt--;
        end
      end else begin
        mem_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  logic        prev_strobe = 0, prev_rd = 0, prev_wr = 0, prev_rdy = 0;
  logic        prev_i_rdy = 0, prev_d_rdy = 0;
  logic [15:0] prev_addr = '0;
  logic [63:0] prev_wdata = '0;
  int n_i = 0, n_d = 0, rd_cyc = 0, serve_i = 0, strobe_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      n_i = 0; n_d = 0; rd_cyc = 0; serve_i = 0; strobe_cyc = 0;
      i_exp.delete();
      d_exp.delete();
      prev_strobe = 0; prev_rd = 0; prev_wr = 0; prev_rdy = 0;
      prev_i_rdy = 0; prev_d_rdy = 0;
    end else begin
      if (m_read || m_write) chk("strobe_exclusive", 64'(m_read & m_write), 0);
      if (prev_strobe && !prev_rdy) begin
        chk("strobe_held", 64'(m_read | m_write), 1);
        chk("addr_stable", m_address, prev_addr);
        chk("wdata_stable", m_wdata, prev_wdata);
        chk("op_stable", {m_read, m_write}, {prev_rd, prev_wr});
      end
      if (prev_rdy) chk("idle_gap", 64'(m_read | m_write), 0);
      chk("i_ready_width", 64'(i_ready & prev_i_rdy), 0);
      chk("d_ready_width", 64'(d_ready & prev_d_rdy), 0);
      chk("both_ready", 64'(i_ready & d_ready), 0);
      if (!i_ready) chk("i_data_zero", i_data, 0);
      if (!d_ready) chk("d_data_zero", d_data, 0);
      if (i_ready) begin
        if (i_exp.size() == 0) chk("i_unexpected", 64'(i_ready), 0);
        else begin
          e = i_exp.pop_front();
          chk("i_data", i_data, e.data);
          chk("i_addr", m_address, e.addr & 16'hFFFC);
          chk("i_op", {m_read, m_write}, 2'b10);
        end
      end
      if (d_ready) begin
        if (d_exp.size() == 0) chk("d_unexpected", 64'(d_ready), 0);
        else begin
          e = d_exp.pop_front();
          chk("d_addr", m_address, e.addr & 16'hFFFC);
          chk("d_op", {m_read, m_write}, e.wr ? 2'b01 : 2'b10);
          if (e.wr) chk("d_wdata", m_wdata, e.data);
          else chk("d_data", d_data, e.data);
        end
      end
      if (i_ready || d_ready) begin
        chk("num_i_grants", num_i_grants, sat(n_i));
        chk("num_d_grants", num_d_grants, sat(n_d));
        chk("num_i_wait", num_i_wait, sat(rd_cyc - serve_i - (i_ready ? strobe_cyc : 0)));
      end
      if (i_read) rd_cyc++;
      if (m_read || m_write) strobe_cyc++;
      if (i_ready) begin
        n_i++;
        serve_i += strobe_cyc;
        strobe_cyc = 0;
        order_q.push_back("I");
      end
      if (d_ready) begin
        n_d++;
        strobe_cyc = 0;
        order_q.push_back("D");
      end
      prev_strobe = m_read | m_write;
      prev_rd = m_read; prev_wr = m_write;
      prev_addr = m_address; prev_wdata = m_wdata;
      prev_rdy = i_ready | d_ready;
      prev_i_rdy = i_ready; prev_d_rdy = d_ready;
    end
  end

  task automatic i_txn(input logic [15:0] a, output int unsigned cyc);
    exp_t e;
    e.addr = a; e.data = ref_rd(a); e.wr = 1'b0;
    i_exp.push_back(e);
    i_address = a;
    i_read = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!i_ready && cyc < 100);
    chk("i_ready_seen", 64'(i_ready), 1);
    @(posedge clk);
    #1;
    i_read = 1'b0;
    i_address = 16'($urandom);
  endtask

  task automatic d_txn(input logic [15:0] a, input logic wr, input logic [63:0] wd, input logic both);
    exp_t e;
    int unsigned n;
    e.addr = a; e.wr = wr;
    if (wr) begin
      e.data = wd;
      ref_mem[a & 16'hFFFC] = wd;
    end else begin
      e.data = ref_rd(a);
    end
    d_exp.push_back(e);
    d_address = a;
    d_wdata = wd;
    d_write = wr;
    d_read = wr ? both : 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ready && n < 100);
    chk("d_ready_seen", 64'(d_ready), 1);
    @(posedge clk);
    #1;
    d_read = 1'b0;
    d_write = 1'b0;
    d_wdata = {$urandom, $urandom};
  endtask

  task automatic check_order(input string want);
    chk("order_len", order_q.size(), want.len());
    for (int k = 0; k < want.len() && k < order_q.size(); k++) chk("order", order_q[k], want[k]);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_i_grants", num_i_grants, sat(n_i));
    chk("idle_d_grants", num_d_grants, sat(n_d));
    chk("idle_i_wait", num_i_wait, sat(rd_cyc - serve_i));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    int unsigned n;
    ref_mem[16'h0010]  = 64'h0004_0003_0002_0001;
    phys_mem[16'h0010] = 64'h0004_0003_0002_0001;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_read", 64'(m_read), 0);
    chk("rst_m_write", 64'(m_write), 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_counters", {num_i_grants, num_d_grants, num_i_wait}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single I read, memory latency 2
    mem_lat_min = 2; mem_lat_max = 2;
    i_txn(16'h0013, cyc);
    chk("t1_latency", cyc, 4);
    settle();
    chk("t1_i_grants", num_i_grants, 1);

    // Single D write
    d_txn(16'h0020, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    settle();
    chk("t2_d_grants", num_d_grants, 1);

    // Simultaneous I and D requests: D wins, I follows
    mem_lat_min = 1; mem_lat_max = 1;
    order_q.delete();
    fork
      i_txn(16'h0100, cyc);
      d_txn(16'h8000, 1'b0, '0, 1'b0);
    join
    check_order("DI");
    settle();

    // Starvation guard with D requesting continuously
    mem_lat_min = 0; mem_lat_max = 2;
    order_q.delete();
    fork
      for (int k = 0; k < 8; k++) d_txn(16'h8000 + 16'(k * 4), 1'b0, '0, 1'b0);
      for (int k = 0; k < 2; k++) i_txn(16'h0200 + 16'(k * 4), cyc);
    join
    check_order("DDDIDDDIDD");
    settle();

    // Random traffic
    mem_lat_min = 0; mem_lat_max = 3;
    fork
      for (int k = 0; k < 40; k++) begin
        int unsigned g;
        i_txn(16'($urandom_range(0, 16'h7FFF)), cyc);
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
      end
      for (int k = 0; k < 40; k++) begin
        int unsigned g;
        d_txn(16'h8000 | 16'($urandom_range(0, 16'h003F)), 1'($urandom), {$urandom, $urandom}, 1'($urandom));
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
      end
    join
    settle();

    // Reset in the middle of a D grant, with m_ready arriving during reset
    mem_lat_min = 1; mem_lat_max = 1;
    d_address = 16'h8100;
    d_wdata = 64'h1234_5678_9ABC_DEF0;
    d_write = 1'b1;
    d_read = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_write && n < 20);
    chk("t5_strobe", 64'(m_write), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_no_ready_in_reset", 64'(d_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    chk("t5_m_write", 64'(m_write), 0);
    chk("t5_m_read", 64'(m_read), 0);
    chk("t5_ready", {i_ready, d_ready}, 0);
    chk("t5_m_address", m_address, 0);
    chk("t5_m_wdata", m_wdata, 0);
    chk("t5_counters", {num_i_grants, num_d_grants, num_i_wait}, 0);
    @(posedge clk);
    #1;
    inject = 1'b1;
    @(negedge clk);
    chk("t5_late_d_ready", 64'(d_ready), 0);
    chk("t5_late_i_ready", 64'(i_ready), 0);
    @(posedge clk);
    #1;

    // Grant counter saturation
    mem_lat_min = 0; mem_lat_max = 0;
    for (int k = 0; k < CMAX + 2; k++)
      d_txn(16'h8000 | 16'($urandom_range(0, 16'h00FF)), 1'b1, {$urandom, $urandom}, 1'b0);
    settle();
    chk("t6_d_saturated", num_d_grants, CMAX);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single line-wide unified memory port between the instruction-fetch requester (I side, read-only) and the data requester (D side, read/write).
- Sits between the CPU's I/D line interfaces and the Memory model. Each access transfers one 4-word line.
- D side has fixed priority over I side. A starvation guard bounds how long a waiting I request can be held off.
- Also exposes saturating grant and wait counters for the testbench's end-of-run summary.

Parameters:
WORD_SIZE, 16, bits per word
LINE_WORDS, 4, words per line; line width = LINE_WORDS*WORD_SIZE
STARVE_LIMIT, 3, max consecutive D grants while an I request waits; the next grant goes to I
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_read  in  1  I requests a line read; held until i_ready
i_address  in  WORD_SIZE  I line address; low 2 bits ignored
i_data  out  LINE_WORDS*WORD_SIZE  read line to I; valid only while i_ready=1
i_ready  out  1  one-cycle completion pulse to I
d_read  in  1  D requests a line read; held until d_ready
d_write  in  1  D requests a line write; held until d_ready
d_address  in  WORD_SIZE  D line address; low 2 bits ignored
d_wdata  in  LINE_WORDS*WORD_SIZE  D write line
d_data  out  LINE_WORDS*WORD_SIZE  read line to D; valid only while d_ready=1
d_ready  out  1  one-cycle completion pulse to D
m_read  out  1  memory read strobe
m_write  out  1  memory write strobe
m_address  out  WORD_SIZE  latched line address, low 2 bits forced to 0
m_wdata  out  LINE_WORDS*WORD_SIZE  latched write line
m_rdata  in  LINE_WORDS*WORD_SIZE  memory read line
m_ready  in  1  memory completion pulse (read data valid / write done)
num_i_grants  out  CNT_W  I transactions completed, saturating
num_d_grants  out  CNT_W  D transactions completed, saturating
num_i_wait  out  CNT_W  cycles with i_read=1 and the arbiter not serving I, saturating

Behaviour:
- Clocking: all state updates on posedge clk.
- Reset: when reset=1 at an edge:
  - state goes to IDLE; m_read, m_write, i_ready, d_ready go to 0.
  - m_address, m_wdata and the starve counter go to 0; all statistics counters go to 0.
  - Reset mid-transaction abandons it: no ready pulse, and any m_ready seen in GRANT_* during reset is ignored.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE arbitration at each edge:
  - If (d_read|d_write) and not (i_read and starve==STARVE_LIMIT): latch d_address, d_wdata and op (write if d_write, else read). Go to GRANT_D.
  - Else if i_read: latch i_address and op=read. Go to GRANT_I.
  - Else stay in IDLE.
  - d_read and d_write both high counts as a write.
- GRANT_x:
  - m_read/m_write are asserted from the latched op (registered outputs).
  - m_address and m_wdata are stable for the whole grant.
  - On m_ready=1, the granted side's ready pulses in that same cycle (combinational from m_ready and state). Its data output = m_rdata; the other side's ready stays 0.
  - At the next edge, go to IDLE and deassert the strobes.
- Minimum spacing: one IDLE cycle between consecutive grants.
- Latency: request seen at edge N → strobe from edge N+1 → ready in the cycle memory raises m_ready.
- m_ready while in IDLE is ignored.
- Starve counter:
  - +1 on each D grant taken while i_read=1.
  - Cleared on each I grant, and on each D grant taken while i_read=0.
  - Saturates at STARVE_LIMIT.
- Requester dropping its request mid-grant: the transaction still completes and the ready pulse is still issued.
- Statistics:
  - grant counters increment in the ready cycle.
  - num_i_wait increments each non-reset cycle with i_read=1 unless state==GRANT_I.
  - All counters hold at 2^CNT_W-1.
- i_data and d_data read as 0 when not in their ready cycle.

Decomposition:
- Shared package holds:
  - arbiter state encoding (IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2);
  - the WORD_SIZE/LINE_WORDS defaults;
  - the line-width derivation.
- Natural sub-module: sat_counter (CNT_W wide, inc, clear, synchronous active-high reset). Instantiated three times for the statistics outputs.

Test Plan:
- Single I read to 0x0013, memory returns line 0x0004_0003_0002_0001 after 2 cycles → m_address=0x0010, i_ready one cycle, i_data=that line, num_i_grants=1.
- D write to 0x0020 with d_wdata=0xAAAA_BBBB_CCCC_DDDD → m_write=1 and m_wdata equal to that value for the full grant, m_read=0 throughout, d_ready one cycle, num_d_grants=1.
- I and D requests rise in the same cycle → GRANT_D first; GRANT_I starts after one IDLE cycle; num_i_wait counts the cycles I is not served.
- D requests continuously while I waits, STARVE_LIMIT=3 → grant order D,D,D,I,D,…
- reset=1 while in GRANT_D before m_ready → next edge all strobes, ready outputs and counters are 0 and state is IDLE. A late m_ready produces no d_ready.
- Force num_d_grants to 0xFFFF, complete one more D transaction → counter stays at 0xFFFF.
